// File: rtl/matrix_stream_mult_pkg.sv
// Shared definitions for the streaming matrix multiplier:
// FSM state encodings and default sizing.
package matrix_stream_mult_pkg;

   localparam int DEF_MAX_SIZE = 10;
   localparam int DEF_DATA_W   = 32;
   localparam int DEF_IDX_W    = 4;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD_A  = 3'd1,
      S_LOAD_B  = 3'd2,
      S_COMPUTE = 3'd3,
      S_EMIT    = 3'd4
   } state_t;

endpackage

// File: rtl/matrix_mac.sv
// Multiply-accumulate step for the matrix multiplier.
// Ports: clk, rst, en (advance acc), first (restart acc from the
// product), a/b operands; sum is the same-cycle running sum,
// truncated to DATA_W (wraps mod 2^DATA_W).
module matrix_mac #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              first,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] sum
);

   logic [DATA_W-1:0] acc_q;
   logic [DATA_W-1:0] prod;

   assign prod = a * b;
   // first drops the stale accumulator so no clear cycle is needed
   assign sum  = (first ? '0 : acc_q) + prod;

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q <= '0;
      end else if (en) begin
         acc_q <= sum;
      end
   end

endmodule

// File: rtl/matrix_stream_mult.sv
// Sequential n x n matrix multiplier: streams in A then B, one MAC
// per cycle computes C = A*B, then streams C out row-major.
// Ports: start/matrix_size begin a job; in_valid/in_ready/in_data
// load A,B; out_valid/out_ready/out_data/out_last emit C;
// busy = not idle; done/err are single-cycle pulses.
module matrix_stream_mult
   import matrix_stream_mult_pkg::*;
#(
   parameter int MAX_SIZE = DEF_MAX_SIZE,
   parameter int DATA_W   = DEF_DATA_W,
   parameter int IDX_W    = DEF_IDX_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [31:0]       matrix_size,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int DEPTH  = MAX_SIZE * MAX_SIZE;
   localparam int ADDR_W = $clog2(DEPTH);

   state_t state_q, state_d;

   logic [IDX_W-1:0] n_m1_q;
   logic [IDX_W-1:0] r_q, c_q, r_nx, c_nx;
   logic [IDX_W-1:0] i_q, j_q, k_q;

   logic [DATA_W-1:0] a_mem [DEPTH];
   logic [DATA_W-1:0] b_mem [DEPTH];
   logic [DATA_W-1:0] c_mem [DEPTH];

   logic [ADDR_W-1:0] rc_addr, ik_addr, kj_addr, ij_addr;
   logic [DATA_W-1:0] mac_sum;

   logic size_ok, in_fire, out_fire;
   logic rc_last, k_last, ijk_last;

   function automatic logic [ADDR_W-1:0] addr(
      input logic [IDX_W-1:0] row,
      input logic [IDX_W-1:0] col
   );
      return ADDR_W'(row) * ADDR_W'(MAX_SIZE) + ADDR_W'(col);
   endfunction

   assign size_ok = (matrix_size != '0) &&
                    (matrix_size <= 32'(MAX_SIZE));

   assign in_ready  = (state_q == S_LOAD_A) ||
                      (state_q == S_LOAD_B);
   assign out_valid = (state_q == S_EMIT);
   assign busy      = (state_q != S_IDLE);
   assign in_fire   = in_valid && in_ready;
   assign out_fire  = out_valid && out_ready;

   assign rc_last  = (r_q == n_m1_q) && (c_q == n_m1_q);
   assign k_last   = (k_q == n_m1_q);
   assign ijk_last = k_last && (j_q == n_m1_q) &&
                     (i_q == n_m1_q);

   assign rc_addr = addr(r_q, c_q);
   assign ik_addr = addr(i_q, k_q);
   assign kj_addr = addr(k_q, j_q);
   assign ij_addr = addr(i_q, j_q);

   // row/col walk shared by loading and emitting, c fastest
   always_comb begin
      c_nx = c_q + 1'b1;
      r_nx = r_q;
      if (c_q == n_m1_q) begin
         c_nx = '0;
         r_nx = (r_q == n_m1_q) ? '0 : r_q + 1'b1;
      end
   end

   assign out_data = out_valid ? c_mem[rc_addr] : '0;
   assign out_last = out_valid && rc_last;

   matrix_mac #(
      .DATA_W (DATA_W)
   ) u_mac (
      .clk   (clk),
      .rst   (rst),
      .en    (state_q == S_COMPUTE),
      .first (k_q == '0),
      .a     (a_mem[ik_addr]),
      .b     (b_mem[kj_addr]),
      .sum   (mac_sum)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (start && size_ok) state_d = S_LOAD_A;
         end
         S_LOAD_A: begin
            if (in_fire && rc_last) state_d = S_LOAD_B;
         end
         S_LOAD_B: begin
            if (in_fire && rc_last) state_d = S_COMPUTE;
         end
         S_COMPUTE: begin
            if (ijk_last) state_d = S_EMIT;
         end
         S_EMIT: begin
            if (out_fire && rc_last) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // counters wrap to zero at the end of each phase, so the
   // next phase always starts from element (0,0)
   always_ff @(posedge clk) begin
      if (rst) begin
         n_m1_q <= '0;
         r_q    <= '0;
         c_q    <= '0;
         i_q    <= '0;
         j_q    <= '0;
         k_q    <= '0;
         done   <= 1'b0;
         err    <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (start && size_ok) begin
                  n_m1_q <= IDX_W'(matrix_size - 32'd1);
                  r_q    <= '0;
                  c_q    <= '0;
                  i_q    <= '0;
                  j_q    <= '0;
                  k_q    <= '0;
               end else if (start) begin
                  err <= 1'b1;
               end
            end
            S_LOAD_A, S_LOAD_B: begin
               if (in_fire) begin
                  r_q <= r_nx;
                  c_q <= c_nx;
               end
            end
            S_COMPUTE: begin
               if (!k_last) begin
                  k_q <= k_q + 1'b1;
               end else begin
                  k_q <= '0;
                  if (j_q != n_m1_q) begin
                     j_q <= j_q + 1'b1;
                  end else begin
                     j_q <= '0;
                     i_q <= (i_q == n_m1_q) ? '0 : i_q + 1'b1;
                  end
               end
            end
            S_EMIT: begin
               if (out_fire) begin
                  r_q <= r_nx;
                  c_q <= c_nx;
                  if (rc_last) done <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // storage is deliberately not reset; a job overwrites what it reads
   always_ff @(posedge clk) begin
      if (state_q == S_LOAD_A && in_fire) begin
         a_mem[rc_addr] <= in_data;
      end
      if (state_q == S_LOAD_B && in_fire) begin
         b_mem[rc_addr] <= in_data;
      end
      if (state_q == S_COMPUTE && k_last) begin
         c_mem[ij_addr] <= mac_sum;
      end
   end

endmodule

// File: tb/tb_matrix_stream_mult.sv
// Directed bench for matrix_stream_mult with a queue scoreboard;
// a negedge monitor checks every output handshake against it.
module tb_matrix_stream_mult;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] matrix_size;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        out_last;
   logic        busy;
   logic        done;
   logic        err;

   matrix_stream_mult dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .matrix_size (matrix_size),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_last    (out_last),
      .busy        (busy),
      .done        (done),
      .err         (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] d;
      logic        l;
   } exp_t;

   exp_t        exp_q [$];
   int          n_cmp = 0;
   int          n_bad = 0;
   bit          rnd_out = 1'b0;
   bit          exp_done = 1'b0;
   bit          hold_v = 1'b0;
   logic [31:0] hold_d;
   logic        hold_l;
   int          comp_cnt = 0;

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // output acceptance, optionally random back-pressure
   always @(posedge clk) begin
      #1;
      out_ready = rnd_out ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // cycles spent computing: busy, not loading, not emitting
   always @(negedge clk) begin
      if (busy && !in_ready && !out_valid) comp_cnt++;
   end

   always @(negedge clk) begin
      if (rst) begin
         hold_v   = 1'b0;
         exp_done = 1'b0;
      end else begin
         if (exp_done) begin
            check("done_pulse", 32'(done), 32'd1);
            check("idle_after_done", 32'(out_valid), 32'd0);
            exp_done = 1'b0;
         end else if (done) begin
            check("spurious_done", 32'(done), 32'd0);
         end
         if (out_valid) begin
            if (hold_v) begin
               check("stall_data", out_data, hold_d);
               check("stall_last", 32'(out_last), 32'(hold_l));
            end
            if (out_ready) begin
               hold_v = 1'b0;
               if (exp_q.size() == 0) begin
                  check("unexpected_out", out_data, 32'hx);
               end else begin
                  exp_t e;
                  e = exp_q.pop_front();
                  check("c_data", out_data, e.d);
                  check("c_last", 32'(out_last), 32'(e.l));
                  if (e.l) exp_done = 1'b1;
               end
            end else begin
               hold_v = 1'b1;
               hold_d = out_data;
               hold_l = out_last;
            end
         end else begin
            hold_v = 1'b0;
         end
      end
   end

   task automatic start_job(input int n);
      @(posedge clk); #1;
      start       = 1'b1;
      matrix_size = 32'(n);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic feed(input logic [31:0] d [$], input bit stall);
      int idx = 0;
      int guard = 0;
      while (idx < d.size() && guard < 5000) begin
         in_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         in_data  = d[idx];
         @(negedge clk);
         if (in_valid && in_ready) idx++;
         guard++;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      if (idx < d.size()) check("feed_timeout", 32'(idx), 32'(d.size()));
   endtask

   task automatic wait_done(input int budget);
      int g = 0;
      @(negedge clk);
      while (!done && g < budget) begin
         @(negedge clk);
         g++;
      end
      if (!done) check("done_timeout", 32'(g), 32'(budget));
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      @(posedge clk); #1;
   endtask

   task automatic run_job(input int n,
                          input logic [31:0] a [$],
                          input logic [31:0] b [$],
                          input logic [31:0] c [$],
                          input bit stall);
      logic [31:0] ab [$];
      for (int i = 0; i < n * n; i++) begin
         exp_t e;
         e.d = c[i];
         e.l = (i == n * n - 1);
         exp_q.push_back(e);
      end
      ab = {a, b};
      comp_cnt = 0;
      start_job(n);
      feed(ab, stall);
      wait_done(20000);
      check("compute_cycles", 32'(comp_cnt), 32'(n * n * n));
   endtask

   logic [31:0] c3 [9] = '{30, 24, 18, 84, 69, 54, 138, 114, 90};
   logic [31:0] qa [$];
   logic [31:0] qb [$];
   logic [31:0] qc [$];

   initial begin
      rst         = 1'b1;
      start       = 1'b0;
      matrix_size = '0;
      in_valid    = 1'b0;
      in_data     = '0;
      out_ready   = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_last", 32'(out_last), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_out_data", out_data, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // n=3, A=1..9, B=9..1
      qa = {}; qb = {}; qc = {};
      for (int i = 0; i < 9; i++) begin
         qa.push_back(32'(i + 1));
         qb.push_back(32'(9 - i));
         qc.push_back(c3[i]);
      end
      run_job(3, qa, qb, qc, 1'b0);

      // n=1, 7*6
      qa = {32'd7}; qb = {32'd6}; qc = {32'd42};
      run_job(1, qa, qb, qc, 1'b0);

      // n=2 wraparound
      qa = {}; qb = {}; qc = {};
      for (int i = 0; i < 4; i++) begin
         qa.push_back(32'h8000_0000);
         qb.push_back(32'd2);
         qc.push_back(32'd0);
      end
      run_job(2, qa, qb, qc, 1'b0);

      // illegal sizes 0 and 11
      for (int t = 0; t < 2; t++) begin
         start_job(t == 0 ? 0 : 11);
         @(negedge clk);
         check("err_pulse", 32'(err), 32'd1);
         check("err_busy", 32'(busy), 32'd0);
         check("err_in_ready", 32'(in_ready), 32'd0);
         @(negedge clk);
         check("err_one_cycle", 32'(err), 32'd0);
         check("err_in_ready2", 32'(in_ready), 32'd0);
      end

      // n=3 with random stalls on both sides
      qa = {}; qb = {}; qc = {};
      for (int i = 0; i < 9; i++) begin
         qa.push_back(32'(i + 1));
         qb.push_back(32'(9 - i));
         qc.push_back(c3[i]);
      end
      rnd_out = 1'b1;
      run_job(3, qa, qb, qc, 1'b1);
      rnd_out = 1'b0;

      // reset mid-compute of n=4, no output expected from it
      qa = {};
      for (int i = 0; i < 32; i++) qa.push_back(32'(i + 3));
      start_job(4);
      qb = {};
      feed(qa, 1'b0);
      repeat (5) @(negedge clk);
      check("in_compute_busy", 32'(busy), 32'd1);
      check("in_compute_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_out_valid", 32'(out_valid), 32'd0);
      qa = {32'd1, 32'd2, 32'd3, 32'd4};
      qb = {32'd1, 32'd0, 32'd0, 32'd1};
      qc = {32'd1, 32'd2, 32'd3, 32'd4};
      run_job(2, qa, qb, qc, 1'b0);

      // n=10 identity * 0..99
      qa = {}; qb = {}; qc = {};
      for (int r = 0; r < 10; r++) begin
         for (int c = 0; c < 10; c++) begin
            qa.push_back(r == c ? 32'd1 : 32'd0);
            qb.push_back(32'(r * 10 + c));
            qc.push_back(32'(r * 10 + c));
         end
      end
      run_job(10, qa, qb, qc, 1'b0);

      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
